// File: rtl/encoder_step_sequencer.sv
// Command-driven step scheduler that issues timed horario/antihorario pulses to the
// quadrature encoder model and tracks the resulting signed position.
module encoder_step_sequencer #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic             horario,
    output logic             antihorario,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left,
    output logic [POS_W-1:0] position
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_state;
    logic             r_dir, w_dir;
    logic [DIV_W-1:0] r_period, w_period;
    logic [DIV_W-1:0] r_timer, w_timer;
    logic [CNT_W-1:0] r_steps, w_steps;
    logic [POS_W-1:0] r_pos, w_pos;
    logic             r_hor, w_hor;
    logic             r_ant, w_ant;
    logic             r_done, w_done;
    logic             r_aborted, w_aborted;
    logic             r_abflag, w_abflag;
    logic             r_busy, w_busy;
    logic             r_ready, w_ready;
    logic [DIV_W-1:0] w_p_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dir     <= 1'b0;
            r_period  <= DIV_W'(1);
            r_timer   <= '0;
            r_steps   <= '0;
            r_pos     <= '0;
            r_hor     <= 1'b0;
            r_ant     <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_abflag  <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_dir     <= w_dir;
            r_period  <= w_period;
            r_timer   <= w_timer;
            r_steps   <= w_steps;
            r_pos     <= w_pos;
            r_hor     <= w_hor;
            r_ant     <= w_ant;
            r_done    <= w_done;
            r_aborted <= w_aborted;
            r_abflag  <= w_abflag;
            r_busy    <= w_busy;
            r_ready   <= w_ready;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_dir     = r_dir;
        w_period  = r_period;
        w_timer   = r_timer;
        w_steps   = r_steps;
        w_pos     = r_pos;
        w_hor     = 1'b0;
        w_ant     = 1'b0;
        w_done    = 1'b0;
        w_aborted = 1'b0;
        w_abflag  = r_abflag;
        w_busy    = r_busy;
        w_ready   = r_ready;
        w_p_eff   = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_ready) begin
                    w_dir    = cmd_dir;
                    w_steps  = cmd_steps;
                    w_period = w_p_eff;
                    w_timer  = w_p_eff - DIV_W'(1);
                    w_abflag = 1'b0;
                    w_busy   = 1'b1;
                    w_ready  = 1'b0;
                    w_state  = (cmd_steps != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_abflag = 1'b1;
                    w_state  = S_DONE;
                end else if (r_timer != '0) begin
                    w_timer = r_timer - DIV_W'(1);
                end else begin
                    w_hor   = r_dir;
                    w_ant   = !r_dir;
                    w_timer = r_period - DIV_W'(1);
                    w_steps = r_steps - CNT_W'(1);
                    w_pos   = r_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
                    if (r_steps == CNT_W'(1)) begin
                        w_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // DONE spans two edges: the first raises the registered done pulse,
                // the second returns to IDLE and re-opens cmd_ready.
                if (!r_done) begin
                    w_done    = 1'b1;
                    w_aborted = r_abflag;
                end else begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    w_ready = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
                w_ready = 1'b1;
            end
        endcase
    end

    assign cmd_ready   = r_ready;
    assign horario     = r_hor;
    assign antihorario = r_ant;
    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign steps_left  = r_steps;
    assign position    = r_pos;

endmodule

// File: tb/tb_encoder_step_sequencer.sv
// Scoreboard bench for encoder_step_sequencer: a 16-bit and a 4-bit position instance
// share stimulus; expected move outcomes are queued and checked by a monitor.
module tb_encoder_step_sequencer;

    typedef struct {
        logic        dir;
        int unsigned p;
        int unsigned done_dt;
        int unsigned pulses;
        logic        ab;
        logic [15:0] sl;
        logic [15:0] pos;
        logic [3:0]  pos4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_dir = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic [15:0] cmd_period = '0;
    logic        abort = 1'b0;

    logic        cmd_ready, horario, antihorario, busy, done, aborted;
    logic [15:0] steps_left, position;
    logic        rdy4, h4, a4, busy4, done4, ab4;
    logic [15:0] sl4;
    logic [3:0]  pos4;

    exp_t        q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    int unsigned accepts = 0;
    int unsigned pulses_seen = 0;
    int unsigned done_cnt = 0;
    logic        post_done = 1'b0;

    always #5 clk = ~clk;

    encoder_step_sequencer #(.CNT_W(16), .DIV_W(16), .POS_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
        .horario(horario), .antihorario(antihorario), .busy(busy), .done(done),
        .aborted(aborted), .steps_left(steps_left), .position(position)
    );

    encoder_step_sequencer #(.CNT_W(16), .DIV_W(16), .POS_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy4),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
        .horario(h4), .antihorario(a4), .busy(busy4), .done(done4),
        .aborted(ab4), .steps_left(sl4), .position(pos4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: counts acceptances at the edge, samples outputs on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n && cmd_valid && cmd_ready) begin
                accepts++;
                acc_cyc = cyc;
            end
            @(negedge clk);
            if (rst_n) begin
                if (post_done) begin
                    chk("ready_after_done", 32'(cmd_ready), 32'd1);
                    chk("busy_after_done", 32'(busy), 32'd0);
                    post_done = 1'b0;
                end
                if (aborted && !done) chk("aborted_without_done", 32'd1, 32'd0);
                if (horario || antihorario) begin
                    if (q.size() == 0) begin
                        chk("unexpected_pulse", 32'd1, 32'd0);
                    end else begin
                        pulses_seen++;
                        chk("pulse_dir", 32'({horario, antihorario}),
                            q[0].dir ? 32'd2 : 32'd1);
                        chk("pulse_time", cyc - acc_cyc, pulses_seen * q[0].p);
                        chk("pulse_dut4", 32'({h4, a4}), 32'({horario, antihorario}));
                    end
                end
                if (done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("done_time", cyc - acc_cyc, e.done_dt);
                        chk("pulse_count", pulses_seen, e.pulses);
                        chk("aborted", 32'(aborted), 32'(e.ab));
                        chk("steps_left", 32'(steps_left), 32'(e.sl));
                        chk("position", 32'(position), 32'(e.pos));
                        chk("position4", 32'(pos4), 32'(e.pos4));
                        chk("accepts_per_move", accepts, 32'd1);
                        chk("ready_in_done", 32'(cmd_ready), 32'd0);
                        chk("busy_in_done", 32'(busy), 32'd1);
                        chk("dut4_done", 32'({done4, ab4, busy4, rdy4}),
                            32'({done, aborted, busy, cmd_ready}));
                        chk("dut4_steps_left", 32'(sl4), 32'(steps_left));
                    end
                    pulses_seen = 0;
                    accepts     = 0;
                    post_done   = 1'b1;
                    done_cnt++;
                end
            end
        end
    end

    task automatic move(input logic dir, input logic [15:0] steps, input logic [15:0] period,
                        input int unsigned ab_edge, input logic ab_acc, input logic hold,
                        input exp_t e);
        bit seen;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_steps  = steps;
        cmd_period = period;
        abort      = ab_acc;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        if (!hold) cmd_valid = 1'b0;
        if (ab_edge != 0) begin
            for (int i = 1; i < int'(ab_edge); i++) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        seen = done;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = done;
        end
        cmd_valid = 1'b0;
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_pulses", 32'({horario, antihorario}), 32'd0);
        chk("rst_busy_done_ab", 32'({busy, done, aborted}), 32'd0);
        chk("rst_steps_left", 32'(steps_left), 32'd0);
        chk("rst_position", 32'(position), 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CCW 5 steps, period 0 behaves as 1: contiguous pulses, done after edge 6
        move(1'b0, 16'd5, 16'd0, 0, 1'b0, 1'b0,
             '{dir: 1'b0, p: 1, done_dt: 6, pulses: 5, ab: 1'b0, sl: 16'd0,
               pos: 16'hFFFB, pos4: 4'hB});

        // abort while idle is ignored
        @(negedge clk); abort = 1'b1;
        repeat (3) @(negedge clk); abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_ready", 32'(cmd_ready), 32'd1);

        // CW 3 steps period 4, abort coinciding with acceptance is ignored
        move(1'b1, 16'd3, 16'd4, 0, 1'b1, 1'b0,
             '{dir: 1'b1, p: 4, done_dt: 13, pulses: 3, ab: 1'b0, sl: 16'd0,
               pos: 16'hFFFE, pos4: 4'hE});

        // zero steps
        move(1'b1, 16'd0, 16'd7, 0, 1'b0, 1'b0,
             '{dir: 1'b1, p: 7, done_dt: 1, pulses: 0, ab: 1'b0, sl: 16'd0,
               pos: 16'hFFFE, pos4: 4'hE});

        // reset in the middle of a run of pulses
        @(negedge clk);
        q.push_back('{dir: 1'b1, p: 1, done_dt: 6, pulses: 5, ab: 1'b0, sl: 16'd0,
                      pos: 16'd0, pos4: 4'd0});
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd5; cmd_period = 16'd1;
        @(negedge clk); cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_pulse", 32'(horario), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pulses", 32'({horario, antihorario, h4, a4}), 32'd0);
        chk("midrst_flags", 32'({busy, done, aborted}), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_steps_left", 32'(steps_left), 32'd0);
        chk("midrst_position", 32'(position), 32'd0);
        q.delete();
        pulses_seen = 0;
        accepts     = 0;
        post_done   = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_position", 32'(position), 32'd0);

        // 17 CW steps with cmd_valid held: 4-bit position wraps to 1, single acceptance
        move(1'b1, 16'd17, 16'd1, 0, 1'b0, 1'b1,
             '{dir: 1'b1, p: 1, done_dt: 18, pulses: 17, ab: 1'b0, sl: 16'd0,
               pos: 16'h0011, pos4: 4'h1});

        // abort sampled at edge 8, one cycle after the 2nd pulse
        move(1'b1, 16'd10, 16'd3, 8, 1'b0, 1'b0,
             '{dir: 1'b1, p: 3, done_dt: 9, pulses: 2, ab: 1'b1, sl: 16'd8,
               pos: 16'h0013, pos4: 4'h3});

        // short CCW move
        move(1'b0, 16'd2, 16'd2, 0, 1'b0, 1'b0,
             '{dir: 1'b0, p: 2, done_dt: 5, pulses: 2, ab: 1'b0, sl: 16'd0,
               pos: 16'h0011, pos4: 4'h1});

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder_step_sequencer.md
# encoder_step_sequencer

Command-driven step scheduler that sequences the quadrature encoder model. Accepts a move command (direction, step count, step period) over a valid/ready handshake and issues single-cycle `horario`/`antihorario` step pulses at the programmed rate. It tracks the resulting signed position and reports completion or abort. It sits directly upstream of the encoder, whose step inputs it drives.

## Interface
- `CNT_W`, 16: width of step count and `steps_left`.
- `DIV_W`, 16: width of step period.
- `POS_W`, 16: width of two's-complement position counter.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_dir`  in  1  1 = clockwise (`horario`), 0 = counter-clockwise (`antihorario`).
- `cmd_steps`  in  CNT_W  number of steps to issue.
- `cmd_period`  in  DIV_W  cycles between step pulses; 0 is treated as 1.
- `abort`  in  1  stop the current move.
- `horario`  out  1  clockwise step pulse to encoder.
- `antihorario`  out  1  counter-clockwise step pulse to encoder.
- `busy`  out  1  move in progress (RUN or DONE).
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  qualifies `done`: the move ended by abort.
- `steps_left`  out  CNT_W  steps not yet issued.
- `position`  out  POS_W  net steps issued since reset, signed.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset values: state IDLE, `cmd_ready`=1, `horario`=`antihorario`=0, `busy`=0, `done`=0, `aborted`=0, `steps_left`=0, `position`=0.
- IDLE: `cmd_ready`=1. A command is accepted on an edge where `cmd_valid`&&`cmd_ready`. The block latches dir, `steps_left`=`cmd_steps`, P=max(`cmd_period`,1), and timer=P-1.
  - If `cmd_steps`≠0, go to RUN. If `cmd_steps`=0, go to DONE.
  - `abort` is ignored in IDLE, including when it coincides with acceptance.
- RUN: `cmd_ready`=0. On each edge:
  - If `abort`=1: no pulse is issued, go to DONE with `aborted`=1. `steps_left` keeps its value.
  - Else if timer≠0: decrement timer.
  - Else (timer=0): assert the direction's pulse for the next cycle, reload timer=P-1, decrement `steps_left`, and update `position` ±1 on the same edge. The edge that issues the pulse for `steps_left`=1 also moves the state to DONE.
- DONE: lasts one cycle with `done`=1, `busy`=1, `cmd_ready`=0, then returns to IDLE. `aborted` is valid only while `done`=1 and is 0 otherwise.
- `horario` and `antihorario` are never high together. Each pulse means exactly one encoder step.
- `position` wraps modulo 2^POS_W and is never cleared except by reset.
- Reset mid-move forces all outputs to their reset values immediately (asynchronous). No partial pulse survives.

## Timing
- Take the acceptance edge as edge 0.
  - Pulse k (k=1..N) is high in the cycle following edge k·P. Pulse spacing is exactly P cycles.
  - With P=1, the pulse output stays high for N consecutive cycles.
- `done` is high in the cycle after edge N·P+1, and `cmd_ready` returns at edge N·P+2.
- For N=0: `done` follows edge 1 and `cmd_ready` returns at edge 2.
- Abort sampled at edge E (in RUN): no pulse follows E. `done`=`aborted`=1 after edge E+1.
- `busy` rises at edge 0 and falls with the IDLE return.
- Back-to-back commands have a minimum gap of one DONE cycle plus one IDLE edge.

## Test plan
- Reset: hold `rst_n` low mid-move → all outputs return to reset values immediately. After release, `cmd_ready`=1, `position`=0.
- Clockwise move, dir=1, steps=3, period=4 → `horario` pulses follow edges 4, 8, 12. `done` follows edge 13 with `aborted`=0, and `position`=3. With the encoder attached, A/B goes 00→10→11→01.
- Counter-clockwise move, dir=0, steps=5, period=0 → `antihorario` is high 5 consecutive cycles, `done` follows edge 6, and `position`=0xFFFB.
- Zero steps, steps=0 → no pulses; `done`=1, `aborted`=0 after edge 1; `cmd_ready`=1 at edge 2; `position` unchanged.
- Abort, steps=10, period=3, `abort` asserted one cycle after the 2nd pulse → exactly 2 pulses. `done`=`aborted`=1, `steps_left`=8, `position`=+2. An `abort` in IDLE has no effect.
- Position wrap, POS_W=4 → 17 clockwise steps from 0 give `position`=1. Throughout the test, `cmd_valid` held high never causes a second acceptance before DONE→IDLE.
